// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared fixed-point types and serializer state encoding
package fnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    typedef logic signed [DATA_WIDTH-1:0] fixed_t;

    typedef enum logic {
        SER_IDLE,
        SER_STREAM
    } ser_state_t;

endpackage

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - two-slot parallel-to-serial vector feeder
module layer_serializer
    import fnn_pkg::*;
#(
    parameter int neuron_number = 10,
    parameter int dataWidth     = DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [neuron_number*dataWidth-1:0] in_vec,
    input  logic                               pause,
    output logic [dataWidth-1:0]               out_data,
    output logic                               out_freeze,
    output logic                               out_last,
    output logic                               vec_done
);

    localparam int IDX_W = $clog2(neuron_number);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(neuron_number - 1);

    typedef logic signed [dataWidth-1:0] elem_t;

    elem_t            active  [neuron_number];
    elem_t            pending [neuron_number];
    ser_state_t       state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             pending_full, pending_full_next;
    logic             ready_ok;
    logic             accept, consume, last_consume;
    logic             load_active_in, load_active_pend, load_pending;

    // ready_ok keeps in_ready low through the reset cycle without looking at rst_n combinationally
    assign in_ready     = ready_ok && !pending_full;
    assign accept       = in_valid && in_ready;
    assign consume      = (state == SER_STREAM) && !pause;
    assign last_consume = consume && (idx == LAST_IDX);

    always_comb begin
        state_next        = state;
        idx_next          = idx;
        pending_full_next = pending_full;
        load_active_in    = 1'b0;
        load_active_pend  = 1'b0;
        load_pending      = 1'b0;
        case (state)
            SER_IDLE: begin
                if (accept) begin
                    load_active_in = 1'b1;
                    state_next     = SER_STREAM;
                    idx_next       = '0;
                end
            end
            SER_STREAM: begin
                if (last_consume) begin
                    idx_next = '0;
                    // Pending full implies no accept this edge, so the two refill sources never collide
                    if (pending_full) begin
                        load_active_pend  = 1'b1;
                        pending_full_next = 1'b0;
                    end else if (accept) begin
                        load_active_in = 1'b1;
                    end else begin
                        state_next = SER_IDLE;
                    end
                end else begin
                    if (consume) begin
                        idx_next = idx + 1'b1;
                    end
                    if (accept) begin
                        load_pending      = 1'b1;
                        pending_full_next = 1'b1;
                    end
                end
            end
            default: state_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SER_IDLE;
            idx          <= '0;
            pending_full <= 1'b0;
            ready_ok     <= 1'b0;
            vec_done     <= 1'b0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            pending_full <= pending_full_next;
            ready_ok     <= 1'b1;
            vec_done     <= last_consume;
        end
    end

    // Slot contents need no reset: they are only observed while the state says they are valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < neuron_number; i++) begin
            if (load_active_in) begin
                active[i] <= in_vec[dataWidth*i +: dataWidth];
            end else if (load_active_pend) begin
                active[i] <= pending[i];
            end
            if (load_pending) begin
                pending[i] <= in_vec[dataWidth*i +: dataWidth];
            end
        end
    end

    assign out_data   = (state == SER_STREAM) ? active[idx] : '0;
    assign out_freeze = (state == SER_IDLE);
    assign out_last   = (state == SER_STREAM) && (idx == LAST_IDX);

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - self-checking bench for layer_serializer
module tb_layer_serializer;

    localparam int N = 10;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_vec;
    logic           pause;
    logic [W-1:0]   out_data;
    logic           out_freeze;
    logic           out_last;
    logic           vec_done;

    always #5 clk = ~clk;

    layer_serializer #(.neuron_number(N), .dataWidth(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .pause      (pause),
        .out_data   (out_data),
        .out_freeze (out_freeze),
        .out_last   (out_last),
        .vec_done   (vec_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of accepted vectors, head is the one streaming, position within it
    typedef logic [W-1:0] vec_t [N];
    vec_t mq[$];
    int   m_idx  = 0;
    bit   m_done = 0;
    bit   m_rdy  = 0;

    always @(posedge clk) begin
        vec_t v;
        bit   acc;
        if (!rst_n) begin
            mq.delete();
            m_idx  = 0;
            m_done = 0;
            m_rdy  = 0;
        end else begin
            acc = in_valid && m_rdy && (mq.size() < 2);
            for (int i = 0; i < N; i++) v[i] = in_vec[W*i +: W];
            m_done = 0;
            if (mq.size() > 0 && !pause) begin
                if (m_idx == N - 1) begin
                    void'(mq.pop_front());
                    m_idx  = 0;
                    m_done = 1;
                end else begin
                    m_idx++;
                end
            end
            if (acc) mq.push_back(v);
            m_rdy = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_freeze", out_freeze, mq.size() == 0);
            chk("model_ready", in_ready, m_rdy && mq.size() < 2);
            chk("model_vec_done", vec_done, m_done);
            chk("model_last", out_last, mq.size() != 0 && m_idx == N - 1);
            if (mq.size() != 0) chk("model_data", out_data, mq[0][m_idx]);
        end
    end

    task automatic set_vec(input int base);
        for (int i = 0; i < N; i++) in_vec[W*i +: W] = W'(base + i);
    endtask

    task automatic scramble_vec();
        for (int i = 0; i < N; i++) in_vec[W*i +: W] = W'($urandom);
    endtask

    task automatic send(input int base);
        in_valid = 1'b1;
        set_vec(base);
        @(negedge clk);
        in_valid = 1'b0;
        scramble_vec();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        pause    = 1'b0;
        in_vec   = '0;
        repeat (2) @(negedge clk);
        chk("rst_freeze", out_freeze, 1);
        chk("rst_data", out_data, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", vec_done, 0);
        cmp_on = 1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", in_ready, 1);

        // Single vector 1..10
        send(1);
        for (int k = 1; k <= N; k++) begin
            chk("single_data", out_data, k);
            chk("single_last", out_last, k == N);
            chk("single_freeze", out_freeze, 0);
            @(negedge clk);
        end
        chk("single_done", vec_done, 1);
        chk("single_idle", out_freeze, 1);
        repeat (2) @(negedge clk);

        // Pause three cycles on element 4
        send(1);
        for (int c = 1; c <= 13; c++) begin
            if (c == 4) pause = 1'b1;
            if (c == 7) pause = 1'b0;
            chk("pause_data", out_data, (c <= 4) ? c : (c <= 7) ? 4 : c - 3);
            chk("pause_last", out_last, c == 13);
            @(negedge clk);
        end
        chk("pause_done", vec_done, 1);
        repeat (2) @(negedge clk);

        // Back-to-back with a third vector held off
        send(1);
        send('h100);
        in_valid = 1'b1;
        set_vec('h200);
        for (int c = 2; c <= 11; c++) begin
            if (c <= 10) chk("b2b_hold_ready", in_ready, 0);
            if (c == 10) chk("b2b_a_last", out_data, 10);
            if (c == 11) begin
                chk("b2b_b_first", out_data, 'h100);
                chk("b2b_no_gap", out_freeze, 0);
                chk("b2b_ready", in_ready, 1);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        scramble_vec();
        repeat (25) @(negedge clk);

        // Accept exactly on the last-consume edge
        send(1);
        repeat (9) @(negedge clk);
        chk("sim_a_last", out_last, 1);
        chk("sim_ready", in_ready, 1);
        send('h300);
        chk("sim_b_first", out_data, 'h300);
        chk("sim_no_gap", out_freeze, 0);
        chk("sim_ready_after", in_ready, 1);
        repeat (12) @(negedge clk);

        // Reset mid-stream with pending occupied
        send(1);
        send('h100);
        repeat (4) @(negedge clk);
        chk("midrst_elem6", out_data, 6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_freeze", out_freeze, 1);
        chk("midrst_data", out_data, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_done", vec_done, 0);
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1);
        chk("midrst_no_done", vec_done, 0);
        send('h400);
        chk("midrst_fresh", out_data, 'h400);
        chk("midrst_fresh_stream", out_freeze, 0);
        repeat (12) @(negedge clk);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            pause    = ($urandom_range(0, 3) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            scramble_vec();
            @(negedge clk);
        end
        in_valid = 1'b0;
        pause    = 1'b0;
        rst_n    = 1'b1;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
